// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StArming    = 2'd1,
    StHeld      = 2'd2,
    StDisarming = 2'd3
  } btn_state_e;

  localparam int unsigned StableCyclesDef = 10000;
  localparam int unsigned RepeatDelayDef  = 5000000;
  localparam int unsigned RepeatPeriodDef = 2000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous ui_in bits; both stages reset to 0.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer with press/release/step pulses.
// Define BTN_REPEAT_EN to add auto-repeat step pulses while the button is held.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = StableCyclesDef,
  parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
  parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_step
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 2);

  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("button_debounce: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic            s;
  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            press_evt;
  logic            release_evt;

  sync_2ff #(
    .Width(1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (i_btn),
    .q    (s)
  );

  // The window closes on the STABLE_CYCLES-th consecutive sample of s.
  assign press_evt   = (state_q == StArming) && s && (cnt_q == StableLast);
  assign release_evt = (state_q == StDisarming) && !s && (cnt_q == StableLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (s) state_q <= StArming;
        end
        StArming: begin
          if (!s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (press_evt) begin
            state_q <= StHeld;
            cnt_q   <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHeld: begin
          cnt_q <= '0;
          if (!s) state_q <= StDisarming;
        end
        StDisarming: begin
          if (s) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (release_evt) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            o_level   <= 1'b0;
            o_release <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_first_q;
  logic            rep_hit;

  assign rep_hit = (rep_cnt_q == (rep_first_q ? DelayLast : PeriodLast));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      o_step      <= 1'b0;
    end else begin
      o_step <= 1'b0;
      if (press_evt) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
        o_step      <= 1'b1;
      end else if ((state_q == StHeld || state_q == StDisarming) && !release_evt) begin
        if (rep_hit) begin
          rep_cnt_q   <= '0;
          rep_first_q <= 1'b0;
          o_step      <= 1'b1;
        end else begin
          rep_cnt_q <= rep_cnt_q + 1'b1;
        end
      end else begin
        // Entering or sitting in IDLE/ARMING drops any pending repeat.
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end
    end
  end
`else
  assign o_step = o_press;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with short debounce and repeat windows.
module tb_button_debounce;

  localparam int unsigned StableCycles = 4;
  localparam int unsigned RepeatDelay  = 20;
  localparam int unsigned RepeatPeriod = 8;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KStep    = 2;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_step;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   press_base = 0;
  ev_t  exp_q[$];

  button_debounce #(
    .STABLE_CYCLES(StableCycles),
    .REPEAT_DELAY (RepeatDelay),
    .REPEAT_PERIOD(RepeatPeriod)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (i_btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_step   (o_step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse seen on an output must match the next expected event in order.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic hit;
      ev_t  e;
      hit = (k == KPress) ? o_press : (k == KRelease) ? o_release : o_step;
      if (hit === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pulse_event: got kind %0d at edge %0d, required no pulse", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc !== cyc || e.kind !== k)
            $display("FAIL pulse_event: got kind %0d at edge %0d, required kind %0d at edge %0d",
                     k, cyc, e.kind, e.cyc);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic push_ev(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_btn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_level, o_press, o_release, o_step} !== 4'b0000)
      $display("FAIL reset_outputs: got %b, required 0000",
               {o_level, o_press, o_release, o_step});
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_level !== 1'b0) $display("FAIL reset_idle_level: got %b, required 0", o_level);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int b;
    b = cyc;
    press_base = b;
    push_ev(b + 15, KPress);
    push_ev(b + 15, KStep);
`ifdef BTN_REPEAT_EN
    push_ev(b + 35, KStep);
    push_ev(b + 43, KStep);
`endif
    wait_to(b + 9);
    i_btn = 1'b1;
    wait_to(b + 14);
    n_checks++;
    if (o_level !== 1'b0) $display("FAIL press_level_early: got %b, required 0", o_level);
    else n_pass++;
    wait_to(b + 15);
    n_checks++;
    if (o_level !== 1'b1) $display("FAIL press_level_rise: got %b, required 1", o_level);
    else n_pass++;
    wait_to(b + 16);
    n_checks++;
    if ({o_press, o_release, o_step} !== 3'b000)
      $display("FAIL press_one_cycle: got %b, required 000", {o_press, o_release, o_step});
    else n_pass++;
  endtask

  task automatic test_release();
    int b;
    b = press_base;
    push_ev(b + 45, KRelease);
    wait_to(b + 39);
    i_btn = 1'b0;
    wait_to(b + 44);
    n_checks++;
    if (o_level !== 1'b1) $display("FAIL release_level_hold: got %b, required 1", o_level);
    else n_pass++;
    wait_to(b + 45);
    n_checks++;
    if (o_level !== 1'b0 || o_step !== 1'b0)
      $display("FAIL release_level_fall: got level %b step %b, required 0 0", o_level, o_step);
    else n_pass++;
    wait_to(b + 55);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL release_missing_events: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce();
    bit pat[12] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    int bad = 0;
    for (int i = 0; i < 12; i++) begin
      i_btn = pat[i];
      @(negedge clk);
      if (o_level !== 1'b0) bad++;
    end
    repeat (10) begin
      @(negedge clk);
      if (o_level !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL bounce_level: got %0d cycles high, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int b;
    b = cyc;
    push_ev(b + 15, KPress);
    push_ev(b + 15, KStep);
`ifdef BTN_REPEAT_EN
    push_ev(b + 35, KStep);
    push_ev(b + 43, KStep);
    push_ev(b + 51, KStep);
    push_ev(b + 59, KStep);
`endif
    push_ev(b + 65, KRelease);
    wait_to(b + 9);
    i_btn = 1'b1;
    wait_to(b + 59);
    i_btn = 1'b0;
    wait_to(b + 64);
    n_checks++;
    if (o_level !== 1'b1) $display("FAIL repeat_level_hold: got %b, required 1", o_level);
    else n_pass++;
    wait_to(b + 80);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL repeat_missing_events: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (o_level !== 1'b0) $display("FAIL repeat_level_end: got %b, required 0", o_level);
    else n_pass++;
  endtask

  task automatic test_reset_mid_hold();
    int b;
    b = cyc;
    push_ev(b + 15, KPress);
    push_ev(b + 15, KStep);
    push_ev(b + 29, KPress);
    push_ev(b + 29, KStep);
    push_ev(b + 45, KRelease);
    wait_to(b + 9);
    i_btn = 1'b1;
    wait_to(b + 20);
    n_checks++;
    if (o_level !== 1'b1) $display("FAIL midhold_level: got %b, required 1", o_level);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_level, o_press, o_release, o_step} !== 4'b0000)
      $display("FAIL midhold_async_clear: got %b, required 0000",
               {o_level, o_press, o_release, o_step});
    else n_pass++;
    wait_to(b + 23);
    rst_n = 1'b1;
    wait_to(b + 28);
    n_checks++;
    if (o_level !== 1'b0) $display("FAIL midhold_relock_early: got %b, required 0", o_level);
    else n_pass++;
    wait_to(b + 29);
    n_checks++;
    if (o_level !== 1'b1) $display("FAIL midhold_relock: got %b, required 1", o_level);
    else n_pass++;
    wait_to(b + 39);
    i_btn = 1'b0;
    wait_to(b + 55);
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL midhold_missing_events: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_repeat();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
